// File: rtl/minterm_encoder.sv
// Minterm encoder: captures a 16-bit request word on start, then streams out the
// index of each set bit (lowest first) under a valid/ready handshake, ending with a done pulse.
module minterm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] d,
  input  logic        ready,
  output logic [3:0]  y,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [4:0]  count
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] pending, pending_next;
  logic [4:0]  count_next;
  logic [15:0] y_mask;
  logic        transfer;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Scanning from the top down lets the lowest set bit win, so bit 0 has priority.
  always_comb begin
    y = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) y = 4'(i);
    end
  end

  assign y_mask   = 16'd1 << y;
  assign valid    = (state == EMIT) && en;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && en;
  assign transfer = valid && ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    count_next   = count;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            pending_next = d;
            count_next   = popcount16(d);
            state_next   = (d != 16'd0) ? EMIT : DONE;
          end
        end
        EMIT: begin
          if (transfer) begin
            pending_next = pending & ~y_mask;
            if ((pending & ~y_mask) == 16'd0) state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      count   <= count_next;
    end
  end

endmodule

// File: doc/minterm_encoder.md
MINTERM_ENCODER -- requirements
Module: minterm_encoder

Interface
REQ-001 Parameters: none; width fixed at 16 request lines to 4-bit index.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  global enable; low freezes all state.
REQ-005 start  input  1  capture request; sampled only in IDLE with en=1.
REQ-006 d  input  16  request lines; bit i set means index i pending.
REQ-007 ready  input  1  consumer accepts y this cycle.
REQ-008 y  output  4  index of lowest pending request.
REQ-009 valid  output  1  y holds a valid index.
REQ-010 busy  output  1  high in EMIT and DONE states.
REQ-011 done  output  1  one-cycle pulse when a job completes.
REQ-012 count  output  5  number of set bits captured at start (0..16).

Function
REQ-013 States SHALL be IDLE, EMIT and DONE, stored in a registered state variable.
REQ-014 IDLE, en=1, start=1: SHALL latch d into a 16-bit pending register and popcount(d) into count.
REQ-015 That IDLE transition SHALL go to EMIT if d!=0, otherwise to DONE.
REQ-016 IDLE with start=0 or en=0 SHALL hold state; pending and count SHALL be unchanged.
REQ-017 In EMIT, y SHALL equal the index of the lowest set bit of pending (pure priority encode, bit 0 highest priority).
REQ-018 valid SHALL equal (state==EMIT) AND en.
REQ-019 A transfer SHALL occur on a rising edge where valid=1 and ready=1; that transfer SHALL clear the bit of pending indexed by y.
REQ-020 After a transfer that empties pending, the next state SHALL be DONE; otherwise it SHALL stay EMIT.
REQ-021 With valid=1 and ready=0, y and pending SHALL hold stable.
REQ-022 With ready held high, throughput SHALL be one index per cycle.
REQ-023 First valid SHALL appear in the cycle after the start edge (latency 1).
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally if en=1.
REQ-025 en=0 in any state SHALL freeze state, pending and count; done SHALL be 0 while en=0.
REQ-026 start asserted while busy=1 SHALL be ignored; d SHALL not be resampled.
REQ-027 count SHALL hold its captured value until the next accepted start or reset.
REQ-028 done SHALL be registered or state-decoded; valid and y SHALL be glitch-free outputs derived from registers.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, pending=0, count=0, y=0, valid=0, busy=0, done=0, independent of clk.
REQ-030 Reset asserted mid-EMIT SHALL abort the job with no done pulse.
REQ-031 After rst deasserts, the first accepted start SHALL behave exactly as from power-up.

Verification
REQ-032 Minterm job: d=16'h28AC, start at edge N, ready=1 -> y=2,3,5,7,11,13 with valid on cycles N+1..N+6, count=6, done=1 at N+7.
REQ-033 Empty job: d=16'h0000, start -> valid never asserts, count=0, done=1 on the cycle after start, IDLE after that.
REQ-034 Backpressure: d=16'h0011, ready=0 for 3 cycles after the first valid -> y=0 held stable for all 3 cycles; then ready=1 -> y=0 then y=4 transfer, done follows.
REQ-035 Full job: d=16'hFFFF, ready=1 -> y=0..15 on 16 consecutive cycles, count=16, single done pulse.
REQ-036 Disruptions: start during EMIT with a new d -> ignored, sequence unchanged; en=0 for 2 cycles mid-EMIT -> valid=0 and frozen, resumes at the same y.
REQ-037 Reset mid-operation: rst pulse at the 3rd transfer of d=16'h28AC -> all outputs 0 asynchronously, no done; a new start with d=16'h0002 -> y=1, count=1, done.
